// File: rtl/pll_reconf_ctrl_pkg.sv
// rtl/pll_reconf_ctrl_pkg.sv - shared states, defaults and counter helper for the PLL reconfig sequencer
package pll_reconf_ctrl_pkg;

  localparam int SCAN_LEN_DEF      = 144;
  localparam int ROM_LATENCY_DEF   = 2;
  localparam int TIMEOUT_DEF       = 4095;
  localparam int ARESET_CYCLES_DEF = 16;
  localparam int CNT_W             = 12;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ        = 3'd1,
    ST_WAIT_RECONF = 3'd2,
    ST_SHIFT       = 3'd3,
    ST_UPDATE      = 3'd4,
    ST_WAIT_DONE   = 3'd5,
    ST_PLL_RESET   = 3'd6,
    ST_WAIT_LOCK   = 3'd7
  } state_e;

  // Saturating increment: the wait counter must never wrap back to a small value
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_scan_shifter.sv
// rtl/pll_scan_shifter.sv - scan-chain buffer and scanclk/scandata generator with start/done handshake
module pll_scan_shifter
  import pll_reconf_ctrl_pkg::*;
#(
  parameter int SCAN_LEN = SCAN_LEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic       wr_data,
  input  logic       start,
  output logic       done,
  output logic       scanclk,
  output logic       scanclkena,
  output logic       scandata
);

  localparam int PH_W  = $clog2(2 * SCAN_LEN);
  localparam int IDX_W = PH_W - 1;

  logic [SCAN_LEN-1:0] sbuf_q, sbuf_d;
  logic [PH_W-1:0]     phase_q, phase_d, ph_next;
  logic                active_q, active_d;
  logic                scanclk_q, scanclk_d;
  logic                scanclkena_q, scanclkena_d;
  logic                scandata_q, scandata_d;
  logic                done_q, done_d;

  // Buffer fill from the ROM read, then one scanclk half-period per clock while active.
  // New data is launched on the falling scanclk so it is stable for the PLL's rising sample.
  always_comb begin
    sbuf_d       = sbuf_q;
    phase_d      = phase_q;
    active_d     = active_q;
    scanclk_d    = scanclk_q;
    scanclkena_d = scanclkena_q;
    scandata_d   = scandata_q;
    done_d       = 1'b0;
    ph_next      = phase_q + PH_W'(1);
    if (wr_en) begin
      sbuf_d[wr_addr[IDX_W-1:0]] = wr_data;
    end
    if (!active_q) begin
      if (start) begin
        active_d     = 1'b1;
        phase_d      = '0;
        scanclk_d    = 1'b0;
        scanclkena_d = 1'b1;
        scandata_d   = sbuf_q[0];
      end
    end else if (phase_q == PH_W'(2 * SCAN_LEN - 1)) begin
      active_d     = 1'b0;
      scanclk_d    = 1'b0;
      scanclkena_d = 1'b0;
      scandata_d   = 1'b0;
      done_d       = 1'b1;
    end else begin
      phase_d   = ph_next;
      scanclk_d = ~scanclk_q;
      if (scanclk_q) begin
        scandata_d = sbuf_q[ph_next[PH_W-1:1]];
      end
    end
  end

  // State registers; reset returns the scan outputs low immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbuf_q       <= '0;
      phase_q      <= '0;
      active_q     <= 1'b0;
      scanclk_q    <= 1'b0;
      scanclkena_q <= 1'b0;
      scandata_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sbuf_q       <= sbuf_d;
      phase_q      <= phase_d;
      active_q     <= active_d;
      scanclk_q    <= scanclk_d;
      scanclkena_q <= scanclkena_d;
      scandata_q   <= scandata_d;
      done_q       <= done_d;
    end
  end

  assign done       = done_q;
  assign scanclk    = scanclk_q;
  assign scanclkena = scanclkena_q;
  assign scandata   = scandata_q;

endmodule

// File: rtl/pll_reconf_ctrl.sv
// rtl/pll_reconf_ctrl.sv - PLL reconfig sequencer: ROM read, scan load, commit, PLL reset and lock wait
module pll_reconf_ctrl
  import pll_reconf_ctrl_pkg::*;
#(
  parameter int SCAN_LEN      = SCAN_LEN_DEF,
  parameter int ROM_LATENCY   = ROM_LATENCY_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int ARESET_CYCLES = ARESET_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_read,
  input  logic       q,
  input  logic       reconfig,
  output logic [7:0] address,
  output logic       read_ena,
  output logic       busy,
  output logic       scanclk,
  output logic       scanclkena,
  output logic       scandata,
  output logic       configupdate,
  input  logic       scandone,
  output logic       pll_areset,
  input  logic       pll_locked,
  output logic       error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       address_q, address_d;
  logic             read_ena_q, read_ena_d;
  logic             configupdate_q, configupdate_d;
  logic             pll_areset_q, pll_areset_d;
  logic             error_q, error_d;
  logic             pending_q, pending_d;
  logic             rcfg_seen_q, rcfg_seen_d;
  logic             timeout_hit, shift_start, shift_done, wr_en;
  logic [7:0]       wr_addr;

  assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));
  assign wr_en       = (state_q == ST_READ) && (cnt_q >= CNT_W'(ROM_LATENCY));
  assign wr_addr     = 8'(cnt_q - CNT_W'(ROM_LATENCY));

  // Sequencer next state; a trigger while busy is remembered once and replayed from IDLE
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    read_ena_d     = 1'b0;
    configupdate_d = 1'b0;
    pll_areset_d   = 1'b0;
    error_d        = 1'b0;
    pending_d      = pending_q | (trigger_read & (state_q != ST_IDLE));
    rcfg_seen_d    = rcfg_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_read || pending_q) begin
          state_d     = ST_READ;
          address_d   = '0;
          read_ena_d  = 1'b1;
          pending_d   = 1'b0;
          rcfg_seen_d = 1'b0;
        end
      end
      ST_READ: begin
        if (reconfig) rcfg_seen_d = 1'b1;
        if (cnt_q < CNT_W'(SCAN_LEN - 1)) begin
          address_d  = address_q + 8'd1;
          read_ena_d = 1'b1;
        end
        if (cnt_q == CNT_W'(SCAN_LEN + ROM_LATENCY - 1)) state_d = ST_WAIT_RECONF;
      end
      ST_WAIT_RECONF: begin
        if (reconfig || rcfg_seen_q) begin
          state_d     = ST_SHIFT;
          rcfg_seen_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d        = ST_UPDATE;
          configupdate_d = 1'b1;
        end
      end
      ST_UPDATE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (scandone) begin
          state_d      = ST_PLL_RESET;
          pll_areset_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_PLL_RESET: begin
        if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else pll_areset_d = 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d       = (state_d != state_q) ? '0 : sat_inc(cnt_q);
    shift_start = (state_q == ST_WAIT_RECONF) && (state_d == ST_SHIFT);
  end

  // Sequencer registers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      address_q      <= '0;
      read_ena_q     <= 1'b0;
      configupdate_q <= 1'b0;
      pll_areset_q   <= 1'b0;
      error_q        <= 1'b0;
      pending_q      <= 1'b0;
      rcfg_seen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      address_q      <= address_d;
      read_ena_q     <= read_ena_d;
      configupdate_q <= configupdate_d;
      pll_areset_q   <= pll_areset_d;
      error_q        <= error_d;
      pending_q      <= pending_d;
      rcfg_seen_q    <= rcfg_seen_d;
    end
  end

  pll_scan_shifter #(.SCAN_LEN(SCAN_LEN)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (q),
    .start      (shift_start),
    .done       (shift_done),
    .scanclk    (scanclk),
    .scanclkena (scanclkena),
    .scandata   (scandata)
  );

  assign address      = address_q;
  assign read_ena     = read_ena_q;
  assign busy         = (state_q != ST_IDLE);
  assign configupdate = configupdate_q;
  assign pll_areset   = pll_areset_q;
  assign error        = error_q;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// tb/tb_pll_reconf_ctrl.sv - directed bench for pll_reconf_ctrl
module tb_pll_reconf_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         trigger_read = 1'b0;
  logic         reconfig = 1'b0;
  logic         scandone = 1'b0;
  logic         pll_locked = 1'b0;
  logic         q;
  logic [7:0]   address;
  logic         read_ena, busy, scanclk, scanclkena, scandata, configupdate, pll_areset, error;

  logic [143:0] rom_bits = '0;
  logic         rom_s1 = 1'b0;
  logic         rom_s2 = 1'b0;

  int           n_vec = 0;
  int           n_err = 0;
  logic         clr = 1'b0;
  int           rises = 0, rd_cnt = 0, addr_err = 0, ares_cnt = 0, cu_cnt = 0, err_cnt = 0;
  logic         sc_prev = 1'b0;
  logic [143:0] cap_vec = '0;

  always #5 clock = ~clock;

  pll_reconf_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .trigger_read (trigger_read),
    .q            (q),
    .reconfig     (reconfig),
    .address      (address),
    .read_ena     (read_ena),
    .busy         (busy),
    .scanclk      (scanclk),
    .scanclkena   (scanclkena),
    .scandata     (scandata),
    .configupdate (configupdate),
    .scandone     (scandone),
    .pll_areset   (pll_areset),
    .pll_locked   (pll_locked),
    .error        (error)
  );

  // ROM with two clocks of read latency
  always @(posedge clock) begin
    rom_s1 <= rom_bits[address];
    rom_s2 <= rom_s1;
  end
  assign q = rom_s2;

  // Observers sampled on the falling clock edge
  always @(negedge clock) begin
    if (clr) begin
      rises = 0; rd_cnt = 0; addr_err = 0; ares_cnt = 0; cap_vec = '0;
    end
    if (scanclk && !sc_prev) begin
      if (rises < 144) cap_vec[rises[7:0]] = scandata;
      rises++;
    end
    sc_prev = scanclk;
    if (read_ena) begin
      if (int'(address) != rd_cnt) addr_err++;
      rd_cnt++;
    end
    if (pll_areset) ares_cnt++;
    if (configupdate) cu_cnt++;
    if (error) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full sequence, entered just after the edge that put the DUT into READ
  task automatic body(input int rc_at, input int done_dly, input int lock_dly, input bit mid_trig,
                      input logic [143:0] exp_bits);
    int k;
    check1("busy_rise", busy, 1'b1);
    check1("rd_ena_start", read_ena, 1'b1);
    checkw("addr_start", int'(address), 0);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (rc_at - 1) step();
    reconfig = 1'b1; step(); reconfig = 1'b0;
    k = 0;
    while (!scanclkena && k < 1000) begin step(); k++; end
    check1("shift_start", scanclkena, 1'b1);
    if (mid_trig) begin
      trigger_read = 1'b1; step(); trigger_read = 1'b0; step();
      trigger_read = 1'b1; step(); trigger_read = 1'b0;
    end
    k = 0;
    while (!configupdate && k < 1000) begin step(); k++; end
    check1("cfgupd_seen", configupdate, 1'b1);
    checkw("scan_rises", rises, 144);
    checkv("scan_bits", cap_vec, exp_bits);
    checkw("rd_ena_cycles", rd_cnt, 144);
    checkw("addr_seq_errs", addr_err, 0);
    check1("scanclkena_off", scanclkena, 1'b0);
    step();
    check1("cfgupd_one_cycle", configupdate, 1'b0);
    repeat (done_dly) step();
    scandone = 1'b1; step(); scandone = 1'b0;
    check1("areset_rise", pll_areset, 1'b1);
    k = 0;
    while (pll_areset && k < 100) begin step(); k++; end
    checkw("areset_cycles", ares_cnt, 16);
    repeat (lock_dly) step();
    pll_locked = 1'b1;
    check1("busy_before_lock", busy, 1'b1);
    step(); pll_locked = 1'b0;
    check1("idle_after_lock", busy, 1'b0);
  endtask

  initial begin
    int c0, e0;
    repeat (3) step();
    checkw("reset_outs", int'({busy, read_ena, scanclk, scanclkena, scandata,
                                configupdate, pll_areset, error, address}), 0);
    reset = 1'b0;
    step();

    // Alternating pattern, reconfig arrives early during READ
    rom_bits = {72{2'b01}};
    c0 = cu_cnt; e0 = err_cnt;
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    body(50, 100, 50, 1'b0, rom_bits);
    checkw("t1_cfgupd_count", cu_cnt - c0, 1);
    checkw("t1_error_count", err_cnt - e0, 0);

    // First and last bit set, reconfig arrives in WAIT_RECONF
    rom_bits = {1'b1, 142'd0, 1'b1};
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    body(200, 3, 2, 1'b0, rom_bits);

    // No reconfig: error exactly 4095 clocks after entering WAIT_RECONF
    c0 = cu_cnt; e0 = err_cnt;
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    repeat (4240) step();
    check1("to_no_error_yet", error, 1'b0);
    check1("to_busy_before", busy, 1'b1);
    step();
    check1("to_error_pulse", error, 1'b1);
    check1("to_busy_drop", busy, 1'b0);
    step();
    check1("to_error_one_cycle", error, 1'b0);
    checkw("to_no_cfgupd", cu_cnt - c0, 0);
    checkw("to_error_count", err_cnt - e0, 1);

    // Triggers during SHIFT collapse to exactly one restart
    rom_bits = {72{2'b10}};
    c0 = cu_cnt;
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    body(150, 5, 5, 1'b1, rom_bits);
    step();
    check1("restart_busy", busy, 1'b1);
    body(60, 5, 5, 1'b0, rom_bits);
    step();
    check1("no_third_run", busy, 1'b0);
    checkw("restart_cfgupd_count", cu_cnt - c0, 2);

    // Asynchronous reset during SHIFT, then a clean sequence
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    repeat (150) step();
    reconfig = 1'b1; step(); reconfig = 1'b0;
    repeat (20) step();
    check1("pre_reset_shifting", scanclkena, 1'b1);
    reset = 1'b1;
    #2;
    checkw("async_reset_outs", int'({busy, read_ena, scanclk, scanclkena, scandata,
                                      configupdate, pll_areset, error, address}), 0);
    step();
    reset = 1'b0;
    step();
    rom_bits = {16'hA5C3, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    c0 = cu_cnt; e0 = err_cnt;
    trigger_read = 1'b1; step(); trigger_read = 1'b0;
    body(100, 10, 10, 1'b0, rom_bits);
    checkw("post_reset_cfgupd", cu_cnt - c0, 1);
    checkw("post_reset_error", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
